// File: rtl/term_ansi_ctrl.sv
// term_ansi_ctrl
//   Terminal controller that sits between the UART receiver and the VGA
//   text buffer. It turns received bytes into character writes and blit
//   requests, tracks the cursor, scrolls, and parses CSI sequences for
//   cursor motion, cursor positioning and erase.
//
// Ports
//   clk100, rst_n            clock, asynchronous active-low reset
//   rx_valid, rx_data        received byte strobe and data
//   wr_en, wr_addr, wr_data  one-cycle character write to the text buffer
//   blit_en                  one-cycle blit request
//   blit_start, blit_end     destination range [start, end)
//   blit_offset              source = dest + offset, 0 = fill with space
//   blit_complete            blit finished strobe
//   cursor_row, cursor_col   current cursor position
//   busy                     a blit is outstanding, no bytes are consumed
//   overflow                 a byte was dropped this cycle
//
// Controller states
//   state          | meaning
//   ST_IDLE        | consume the held byte, if any
//   ST_SCROLL_CP   | copy rows 1..ROWS-1 up by one row, wait for completion
//   ST_SCROLL_CLR  | blank the last row, wait for completion
//   ST_CLR_WAIT    | erase (J/K) blit outstanding, wait for completion
//
// Parser states
//   pstate         | meaning
//   PS_GROUND      | printable characters and control codes
//   PS_ESC         | ESC seen, expecting '['
//   PS_CSI         | collecting parameters until a final byte
module term_ansi_ctrl #(
   parameter int COLS   = 80,
   parameter int ROWS   = 25,
   parameter int ADDR_W = 11,
   parameter int TAB_W  = 8
) (
   input  logic              clk100,
   input  logic              rst_n,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              blit_en,
   output logic [ADDR_W-1:0] blit_start,
   output logic [ADDR_W-1:0] blit_end,
   output logic [7:0]        blit_offset,
   input  logic              blit_complete,
   output logic [5:0]        cursor_row,
   output logic [6:0]        cursor_col,
   output logic              busy,
   output logic              overflow
);

   localparam logic [1:0] ST_IDLE       = 2'd0;
   localparam logic [1:0] ST_SCROLL_CP  = 2'd1;
   localparam logic [1:0] ST_SCROLL_CLR = 2'd2;
   localparam logic [1:0] ST_CLR_WAIT   = 2'd3;

   localparam logic [1:0] PS_GROUND = 2'd0;
   localparam logic [1:0] PS_ESC    = 2'd1;
   localparam logic [1:0] PS_CSI    = 2'd2;

   localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
   localparam logic [ADDR_W-1:0] LAST_ROW_A = ADDR_W'((ROWS - 1) * COLS);
   localparam logic [ADDR_W-1:0] CELLS_A    = ADDR_W'(ROWS * COLS);
   localparam logic [7:0]        COLS_B     = 8'(COLS);
   localparam logic [5:0]        ROW_MAX    = 6'(ROWS - 1);
   localparam logic [6:0]        COL_MAX    = 7'(COLS - 1);
   localparam logic signed [9:0] ROW_MAX_S  = 10'(ROWS - 1);
   localparam logic signed [9:0] COL_MAX_S  = 10'(COLS - 1);
   localparam logic [7:0]        TAB_MASK   = 8'(TAB_W - 1);
   localparam logic [7:0]        TAB_STEP   = 8'(TAB_W);

   // Cursor math runs in 10-bit signed so that a 255-step move from any
   // position can neither wrap nor change sign before clamping.
   function automatic logic [5:0] clamp_row(input logic signed [9:0] v);
      if (v < 10'sd0)          return 6'd0;
      else if (v > ROW_MAX_S)  return ROW_MAX;
      else                     return v[5:0];
   endfunction

   function automatic logic [6:0] clamp_col(input logic signed [9:0] v);
      if (v < 10'sd0)          return 7'd0;
      else if (v > COL_MAX_S)  return COL_MAX;
      else                     return v[6:0];
   endfunction

   logic [1:0]        state_q, state_d;
   logic [1:0]        pstate_q, pstate_d;
   logic [7:0]        p0_q, p0_d;
   logic [7:0]        p1_q, p1_d;
   logic              idx_q, idx_d;
   logic              hold_full_q, hold_full_d;
   logic [7:0]        hold_data_q, hold_data_d;
   logic [5:0]        row_q, row_d;
   logic [6:0]        col_q, col_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              blit_en_q, blit_en_d;
   logic [ADDR_W-1:0] blit_start_q, blit_start_d;
   logic [ADDR_W-1:0] blit_end_q, blit_end_d;
   logic [7:0]        blit_offset_q, blit_offset_d;

   logic              consume;
   logic              blit_done;
   logic [7:0]        byte_c;
   logic [ADDR_W-1:0] row_a;
   logic [ADDR_W-1:0] cur_addr;
   logic [7:0]        n_c;
   logic [7:0]        n1_c;
   logic [7:0]        p_sel;
   logic [11:0]       p_acc;
   logic [7:0]        p_digit;
   logic signed [9:0] row_s;
   logic signed [9:0] col_s;
   logic signed [9:0] n_s;
   logic [7:0]        tab_c;
   logic [6:0]        tab_col;

   assign consume   = (state_q == ST_IDLE) && hold_full_q;
   // A completion in the same cycle as the request belongs to no blit of ours.
   assign blit_done = blit_complete && !blit_en_q;
   assign byte_c    = hold_data_q;

   assign row_a    = ADDR_W'(row_q);
   assign cur_addr = row_a * COLS_A + ADDR_W'(col_q);

   assign n_c     = (p0_q == 8'd0) ? 8'd1 : p0_q;
   assign n1_c    = (p1_q == 8'd0) ? 8'd1 : p1_q;
   assign p_sel   = idx_q ? p1_q : p0_q;
   assign p_acc   = {4'd0, p_sel} * 12'd10 + {8'd0, byte_c[3:0]};
   assign p_digit = (p_acc > 12'd255) ? 8'hFF : p_acc[7:0];

   assign row_s = $signed({4'd0, row_q});
   assign col_s = $signed({3'd0, col_q});
   assign n_s   = $signed({2'd0, n_c});

   assign tab_c   = ({1'b0, col_q} & ~TAB_MASK) + TAB_STEP;
   assign tab_col = (tab_c > {1'b0, COL_MAX}) ? COL_MAX : tab_c[6:0];

   always_comb begin
      logic lf;
      lf            = 1'b0;
      state_d       = state_q;
      pstate_d      = pstate_q;
      p0_d          = p0_q;
      p1_d          = p1_q;
      idx_d         = idx_q;
      row_d         = row_q;
      col_d         = col_q;
      hold_full_d   = hold_full_q;
      hold_data_d   = hold_data_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      blit_en_d     = 1'b0;
      blit_start_d  = blit_start_q;
      blit_end_d    = blit_end_q;
      blit_offset_d = blit_offset_q;

      // The slot freed by consumption can be refilled in the same cycle.
      if (consume) hold_full_d = 1'b0;
      if (rx_valid && (!hold_full_q || consume)) begin
         hold_full_d = 1'b1;
         hold_data_d = rx_data;
      end

      case (state_q)
         ST_IDLE: begin
            if (consume) begin
               case (pstate_q)
                  PS_GROUND: begin
                     if (byte_c >= 8'h20 && byte_c <= 8'h7E) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cur_addr;
                        wr_data_d = byte_c;
                        if (col_q == COL_MAX) begin
                           col_d = 7'd0;
                           lf    = 1'b1;
                        end else begin
                           col_d = col_q + 7'd1;
                        end
                     end else begin
                        case (byte_c)
                           8'h0A: lf = 1'b1;
                           8'h0D: col_d = 7'd0;
                           8'h08: col_d = (col_q == 7'd0) ? 7'd0 : col_q - 7'd1;
                           8'h09: col_d = tab_col;
                           8'h1B: pstate_d = PS_ESC;
                           default: ;
                        endcase
                     end
                  end
                  PS_ESC: begin
                     if (byte_c == 8'h5B) begin
                        p0_d     = 8'd0;
                        p1_d     = 8'd0;
                        idx_d    = 1'b0;
                        pstate_d = PS_CSI;
                     end else begin
                        pstate_d = PS_GROUND;
                     end
                  end
                  PS_CSI: begin
                     if (byte_c >= 8'h30 && byte_c <= 8'h39) begin
                        if (idx_q) p1_d = p_digit;
                        else       p0_d = p_digit;
                     end else if (byte_c == 8'h3B) begin
                        idx_d = 1'b1;
                     end else if (byte_c == 8'h1B) begin
                        pstate_d = PS_ESC;
                     end else if (byte_c >= 8'h40 && byte_c <= 8'h7E) begin
                        pstate_d = PS_GROUND;
                        case (byte_c)
                           8'h41: row_d = clamp_row(row_s - n_s);
                           8'h42: row_d = clamp_row(row_s + n_s);
                           8'h43: col_d = clamp_col(col_s + n_s);
                           8'h44: col_d = clamp_col(col_s - n_s);
                           8'h48, 8'h66: begin
                              row_d = clamp_row($signed({2'd0, n_c}) - 10'sd1);
                              col_d = clamp_col($signed({2'd0, n1_c}) - 10'sd1);
                           end
                           8'h4A: begin
                              if (p0_q == 8'd2) begin
                                 blit_en_d     = 1'b1;
                                 blit_start_d  = '0;
                                 blit_end_d    = CELLS_A;
                                 blit_offset_d = 8'd0;
                                 state_d       = ST_CLR_WAIT;
                              end
                           end
                           8'h4B: begin
                              if (p0_q == 8'd0) begin
                                 blit_en_d     = 1'b1;
                                 blit_start_d  = cur_addr;
                                 blit_end_d    = row_a * COLS_A + COLS_A;
                                 blit_offset_d = 8'd0;
                                 state_d       = ST_CLR_WAIT;
                              end
                           end
                           default: ;
                        endcase
                     end
                  end
                  default: pstate_d = PS_GROUND;
               endcase

               if (lf) begin
                  if (row_q < ROW_MAX) begin
                     row_d = row_q + 6'd1;
                  end else begin
                     blit_en_d     = 1'b1;
                     blit_start_d  = '0;
                     blit_end_d    = LAST_ROW_A;
                     blit_offset_d = COLS_B;
                     state_d       = ST_SCROLL_CP;
                  end
               end
            end
         end
         ST_SCROLL_CP: begin
            if (blit_done) begin
               blit_en_d     = 1'b1;
               blit_start_d  = LAST_ROW_A;
               blit_end_d    = CELLS_A;
               blit_offset_d = 8'd0;
               state_d       = ST_SCROLL_CLR;
            end
         end
         ST_SCROLL_CLR, ST_CLR_WAIT: begin
            if (blit_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         pstate_q      <= PS_GROUND;
         p0_q          <= 8'd0;
         p1_q          <= 8'd0;
         idx_q         <= 1'b0;
         hold_full_q   <= 1'b0;
         hold_data_q   <= 8'd0;
         row_q         <= 6'd0;
         col_q         <= 7'd0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= 8'd0;
         blit_en_q     <= 1'b0;
         blit_start_q  <= '0;
         blit_end_q    <= '0;
         blit_offset_q <= 8'd0;
      end else begin
         state_q       <= state_d;
         pstate_q      <= pstate_d;
         p0_q          <= p0_d;
         p1_q          <= p1_d;
         idx_q         <= idx_d;
         hold_full_q   <= hold_full_d;
         hold_data_q   <= hold_data_d;
         row_q         <= row_d;
         col_q         <= col_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         blit_en_q     <= blit_en_d;
         blit_start_q  <= blit_start_d;
         blit_end_q    <= blit_end_d;
         blit_offset_q <= blit_offset_d;
      end
   end

   assign wr_en       = wr_en_q;
   assign wr_addr     = wr_addr_q;
   assign wr_data     = wr_data_q;
   assign blit_en     = blit_en_q;
   assign blit_start  = blit_start_q;
   assign blit_end    = blit_end_q;
   assign blit_offset = blit_offset_q;
   assign cursor_row  = row_q;
   assign cursor_col  = col_q;
   assign busy        = (state_q != ST_IDLE);
   assign overflow    = rx_valid && hold_full_q && !consume;

endmodule

// File: tb/tb_term_ansi_ctrl.sv
// Testbench for term_ansi_ctrl: directed scenarios plus a random byte stream,
// all checked every cycle against a queue-based behavioural terminal model.
module tb_term_ansi_ctrl;

   localparam int COLS   = 80;
   localparam int ROWS   = 25;
   localparam int ADDR_W = 11;
   localparam int TAB_W  = 8;

   logic              clk100 = 1'b0;
   logic              rst_n  = 1'b1;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data  = 8'd0;
   logic              blit_complete = 1'b0;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              blit_en;
   logic [ADDR_W-1:0] blit_start;
   logic [ADDR_W-1:0] blit_end;
   logic [7:0]        blit_offset;
   logic [5:0]        cursor_row;
   logic [6:0]        cursor_col;
   logic              busy;
   logic              overflow;

   always #5 clk100 = ~clk100;

   term_ansi_ctrl #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .TAB_W(TAB_W)) dut (
      .clk100        (clk100),
      .rst_n         (rst_n),
      .rx_valid      (rx_valid),
      .rx_data       (rx_data),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .blit_en       (blit_en),
      .blit_start    (blit_start),
      .blit_end      (blit_end),
      .blit_offset   (blit_offset),
      .blit_complete (blit_complete),
      .cursor_row    (cursor_row),
      .cursor_col    (cursor_col),
      .busy          (busy),
      .overflow      (overflow)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {int s; int e; int o;} blit_t;
   blit_t m_bq[$];     // outstanding blits, head is the one on the bus
   int    m_hold[$];   // holding register, at most one byte
   int    m_row, m_col, m_pst, m_p0, m_p1, m_idx;
   bit    e_wr, e_blit;
   int    e_addr, e_data;

   function automatic int imin(int a, int b); return (a < b) ? a : b; endfunction
   function automatic int imax(int a, int b); return (a > b) ? a : b; endfunction
   function automatic int clampi(int v, int hi); return imin(imax(v, 0), hi); endfunction

   function void m_reset();
      m_bq.delete(); m_hold.delete();
      m_row = 0; m_col = 0; m_pst = 0; m_p0 = 0; m_p1 = 0; m_idx = 0;
      e_wr = 0; e_blit = 0; e_addr = 0; e_data = 0;
   endfunction

   function void m_lf();
      if (m_row < ROWS - 1) m_row++;
      else begin
         m_bq.push_back('{0, (ROWS - 1) * COLS, COLS});
         m_bq.push_back('{(ROWS - 1) * COLS, ROWS * COLS, 0});
         e_blit = 1;
      end
   endfunction

   function void m_exec(int f);
      int n;
      n = (m_p0 == 0) ? 1 : m_p0;
      case (f)
         "A": m_row = clampi(m_row - n, ROWS - 1);
         "B": m_row = clampi(m_row + n, ROWS - 1);
         "C": m_col = clampi(m_col + n, COLS - 1);
         "D": m_col = clampi(m_col - n, COLS - 1);
         "H", "f": begin
            m_row = clampi(n - 1, ROWS - 1);
            m_col = clampi(((m_p1 == 0) ? 1 : m_p1) - 1, COLS - 1);
         end
         "J": if (m_p0 == 2) begin m_bq.push_back('{0, ROWS * COLS, 0}); e_blit = 1; end
         "K": if (m_p0 == 0) begin
            m_bq.push_back('{m_row * COLS + m_col, (m_row + 1) * COLS, 0}); e_blit = 1;
         end
         default: ;
      endcase
   endfunction

   function void m_byte(int b);
      case (m_pst)
         0: begin
            if (b >= 32 && b <= 126) begin
               e_wr = 1; e_addr = m_row * COLS + m_col; e_data = b;
               if (m_col == COLS - 1) begin m_col = 0; m_lf(); end
               else m_col++;
            end else if (b == 10) m_lf();
            else if (b == 13) m_col = 0;
            else if (b == 8) m_col = imax(m_col - 1, 0);
            else if (b == 9) m_col = imin((m_col / TAB_W + 1) * TAB_W, COLS - 1);
            else if (b == 27) m_pst = 1;
         end
         1: begin
            if (b == "[") begin m_p0 = 0; m_p1 = 0; m_idx = 0; m_pst = 2; end
            else m_pst = 0;
         end
         default: begin
            if (b >= "0" && b <= "9") begin
               if (m_idx == 0) m_p0 = imin(m_p0 * 10 + (b - "0"), 255);
               else            m_p1 = imin(m_p1 * 10 + (b - "0"), 255);
            end else if (b == ";") m_idx = imin(m_idx + 1, 1);
            else if (b == 27) m_pst = 1;
            else if (b >= 8'h40 && b <= 8'h7E) begin m_pst = 0; m_exec(b); end
         end
      endcase
   endfunction

   function void m_step(bit rxv, int rxd, bit bc);
      bit consume, prev_blit;
      consume   = (m_bq.size() == 0) && (m_hold.size() == 1);
      prev_blit = e_blit;
      e_wr = 0; e_blit = 0;
      if (m_bq.size() > 0 && bc && !prev_blit) begin
         void'(m_bq.pop_front());
         if (m_bq.size() > 0) e_blit = 1;
      end
      if (consume) m_byte(m_hold.pop_front());
      if (rxv && m_hold.size() == 0) m_hold.push_back(rxd);
   endfunction

   always @(posedge clk100 or negedge rst_n) begin
      if (!rst_n) m_reset();
      else m_step(rx_valid, int'(rx_data), blit_complete);
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk100) begin
      chk("wr_en", 32'(wr_en), 32'(e_wr));
      if (e_wr) begin
         chk("wr_addr", 32'(wr_addr), e_addr);
         chk("wr_data", 32'(wr_data), e_data);
      end
      chk("blit_en", 32'(blit_en), 32'(e_blit));
      if (m_bq.size() > 0) begin
         chk("blit_start", 32'(blit_start), m_bq[0].s);
         chk("blit_end", 32'(blit_end), m_bq[0].e);
         chk("blit_offset", 32'(blit_offset), m_bq[0].o);
      end
      chk("busy", 32'(busy), 32'(m_bq.size() > 0));
      chk("cursor_row", 32'(cursor_row), m_row);
      chk("cursor_col", 32'(cursor_col), m_col);
      chk("overflow", 32'(overflow),
          32'(rx_valid && m_hold.size() == 1 && m_bq.size() > 0));
   end

   // ---------------- DUT activity logs for directed checks ----------------
   int wr_a[$], wr_d[$], bl_s[$], bl_e[$], bl_o[$];
   int ovf_cnt = 0;

   always @(negedge clk100) begin
      if (wr_en) begin wr_a.push_back(int'(wr_addr)); wr_d.push_back(int'(wr_data)); end
      if (blit_en) begin
         bl_s.push_back(int'(blit_start)); bl_e.push_back(int'(blit_end));
         bl_o.push_back(int'(blit_offset));
      end
      if (overflow) ovf_cnt++;
   end

   function automatic int qget(input int q[$], input int i);
      return (i >= 0 && i < q.size()) ? q[i] : -1;
   endfunction

   function void clear_logs();
      wr_a.delete(); wr_d.delete(); bl_s.delete(); bl_e.delete(); bl_o.delete();
      ovf_cnt = 0;
   endfunction

   // ---------------- blit_complete responder ----------------
   int bc_mode  = 0;   // 0 off, 1 fixed delay after each request, 2 random pulses
   int bc_delay = 3;

   initial begin
      int cd;
      cd = 0;
      forever begin
         @(posedge clk100); #1;
         if (bc_mode == 2) blit_complete = ($urandom_range(0, 5) == 0);
         else if (bc_mode == 1) begin
            blit_complete = 1'b0;
            if (blit_en) cd = bc_delay;
            else if (cd > 0) begin
               cd--;
               if (cd == 0) blit_complete = 1'b1;
            end
         end else blit_complete = 1'b0;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(); @(posedge clk100); #1; endtask

   task automatic wait_idle();
      int k;
      k = 0;
      tick();
      while ((busy || m_hold.size() != 0) && k < 3000) begin tick(); k++; end
      chk("wait_idle_timeout", 32'(k >= 3000), 0);
      tick(); tick();
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1; rx_data = b; tick(); rx_valid = 1'b0;
      wait_idle();
   endtask

   task automatic send_csi(input string s);
      send_byte(8'h1B); send_byte(8'h5B);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   function automatic logic [7:0] rnd_byte();
      string fin;
      fin = "ABCDHfJK";
      case ($urandom_range(0, 9))
         0, 1, 2: return 8'($urandom_range(32, 126));
         3:       return 8'h1B;
         4:       return 8'h5B;
         5:       return 8'($urandom_range(48, 57));
         6:       return 8'h3B;
         7:       return fin[$urandom_range(0, 7)];
         8: case ($urandom_range(0, 3))
               0: return 8'h0A; 1: return 8'h0D; 2: return 8'h08; default: return 8'h09;
            endcase
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk100);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_cursor", {cursor_row, cursor_col}, 0);
      rst_n = 1'b1;
      tick();
      bc_mode = 1; bc_delay = 3;

      // "AB\r\n" from reset
      clear_logs();
      send_byte("A"); send_byte("B"); send_byte(8'h0D); send_byte(8'h0A);
      chk("t1_nwr", wr_a.size(), 2);
      chk("t1_addr0", qget(wr_a, 0), 0);
      chk("t1_data0", qget(wr_d, 0), 65);
      chk("t1_addr1", qget(wr_a, 1), 1);
      chk("t1_data1", qget(wr_d, 1), 66);
      chk("t1_row", 32'(cursor_row), 1);
      chk("t1_col", 32'(cursor_col), 0);
      chk("t1_model_row", m_row, 1);
      chk("t1_nblit", bl_s.size(), 0);

      // 81 printable bytes on row 0
      send_csi("H");
      clear_logs();
      for (int i = 0; i < 81; i++) send_byte(8'(97 + i % 26));
      chk("t2_nwr", wr_a.size(), 81);
      chk("t2_last_addr", qget(wr_a, 80), 80);
      chk("t2_row", 32'(cursor_row), 1);
      chk("t2_col", 32'(cursor_col), 1);

      // scroll from (24,5)
      bc_delay = 10;
      send_csi("25;6H");
      clear_logs();
      send_byte(8'h0A);
      chk("t3_nblit", bl_s.size(), 2);
      chk("t3_b0_start", qget(bl_s, 0), 0);
      chk("t3_b0_end", qget(bl_e, 0), 1920);
      chk("t3_b0_off", qget(bl_o, 0), 80);
      chk("t3_b1_start", qget(bl_s, 1), 1920);
      chk("t3_b1_end", qget(bl_e, 1), 2000);
      chk("t3_b1_off", qget(bl_o, 1), 0);
      chk("t3_cursor", {cursor_row, cursor_col}, {6'd24, 7'd5});
      chk("t3_busy", 32'(busy), 0);

      // cursor positioning
      bc_delay = 3;
      send_csi("12;40H");
      clear_logs();
      send_byte("X");
      chk("t4_addr", qget(wr_a, 0), 919);
      chk("t4_data", qget(wr_d, 0), 88);
      send_csi("999;999H");
      chk("t4_clamp", {cursor_row, cursor_col}, {6'd24, 7'd79});
      send_csi("4;1H");
      send_csi("0A");
      chk("t4_up", 32'(cursor_row), 2);
      chk("t4_model_up", m_row, 2);

      // bytes arriving during a scroll wait
      bc_delay = 10;
      send_csi("25;1H");
      clear_logs();
      rx_valid = 1'b1;
      rx_data = 8'h0A; tick();
      rx_data = "P";   tick();
      rx_data = "Q";   tick();
      rx_data = "R";   tick();
      rx_valid = 1'b0;
      wait_idle();
      chk("t5_ovf", ovf_cnt, 2);
      chk("t5_nwr", wr_a.size(), 1);
      chk("t5_addr", qget(wr_a, 0), 1920);
      chk("t5_data", qget(wr_d, 0), 80);
      chk("t5_cursor", {cursor_row, cursor_col}, {6'd24, 7'd1});

      // erase commands, reset during the wait
      bc_delay = 3;
      clear_logs();
      send_csi("2J");
      chk("t6_j_start", qget(bl_s, 0), 0);
      chk("t6_j_end", qget(bl_e, 0), 2000);
      chk("t6_j_off", qget(bl_o, 0), 0);
      send_csi("3;11H");
      bc_delay = 30;
      clear_logs();
      send_byte(8'h1B); send_byte(8'h5B);
      rx_valid = 1'b1; rx_data = "K"; tick(); rx_valid = 1'b0;
      tick(); tick(); tick();
      chk("t6_k_start", qget(bl_s, 0), 170);
      chk("t6_k_end", qget(bl_e, 0), 240);
      chk("t6_k_off", qget(bl_o, 0), 0);
      chk("t6_k_busy", 32'(busy), 1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_blit_end", 32'(blit_end), 0);
      chk("t6_rst_cursor", {cursor_row, cursor_col}, 0);
      tick(); tick();
      rst_n = 1'b1;
      repeat (35) tick();
      clear_logs();
      send_byte("Z");
      chk("t6_after_addr", qget(wr_a, 0), 0);
      chk("t6_after_data", qget(wr_d, 0), 90);
      chk("t6_after_nblit", bl_s.size(), 0);

      // random stream, random completion timing
      bc_mode = 2;
      for (int i = 0; i < 5000; i++) begin
         rx_valid = ($urandom_range(0, 3) == 0);
         rx_data  = rnd_byte();
         tick();
      end
      rx_valid = 1'b0;
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
